nanci_result_collector: RTL and testbench
=========================================

# nanci_result_collector

Downstream drain stage for `mesh_db`. When the mesh signals that a sort/route round has finished, the block snapshots the packed per-node `nanci_result` words. It then scans node 0 to N-1 and emits every valid entry, one per handshake, on a valid/ready stream toward host-side logic or a scoreboard. Invalid entries are skipped. The block reports completion and emit count, and flags rounds that arrive while a drain is still in progress.

## Interface
- `N`, 4, number of mesh nodes.
- `ADDR_WIDTH`, 2, address field width.
- `DATA_WIDTH`, 2, data field width.
- `WIDTH`, `ADDR_WIDTH+DATA_WIDTH`, payload width (derived; do not override).
- `IDX_WIDTH`, 2, node index width; equals ceil(log2 N) and must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `round_done`  in  1  one-cycle pulse; `nanci_result_flat` is stable in this cycle.
- `nanci_result_flat`  in  N*(WIDTH+1)  node i occupies bits `[(i+1)*(WIDTH+1)-1 : i*(WIDTH+1)]`. Within a node word: bit WIDTH = valid, `[WIDTH-1:DATA_WIDTH]` = addr, `[DATA_WIDTH-1:0]` = data.
- `out_valid`  out  1  output entry present.
- `out_ready`  in  1  consumer accepts.
- `out_node`  out  IDX_WIDTH  source node index.
- `out_addr`  out  ADDR_WIDTH  entry address.
- `out_data`  out  DATA_WIDTH  entry data.
- `busy`  out  1  high in SCAN and DONE.
- `drain_done`  out  1  one-cycle pulse at the end of a drain.
- `emit_count`  out  IDX_WIDTH+1  entries emitted in the last drain; updated when `drain_done` rises, held otherwise.
- `overrun`  out  1  sticky; a `round_done` arrived while `busy`.

## Operation
- **States**
  - IDLE: waits for `round_done`.
  - SCAN: walks the snapshot and emits valid entries.
  - DONE: lasts one cycle and pulses `drain_done`.
- **IDLE + `round_done`**
  - Capture all N words into the snapshot registers.
  - Set `idx`=0 and clear the running count.
  - Go to SCAN.
- **SCAN, output register free** (free means `!out_valid` or `out_valid && out_ready`):
  - If `idx`<N and `snapshot[idx]` is valid, load it into the output registers, drive `out_valid`=1, and increment the count.
  - If `idx`<N and the entry is invalid, leave `out_valid` deasserted.
  - In either case, increment `idx`.
- **SCAN, output not free:** all state holds. Output fields are stable while `out_valid && !out_ready`.
- **SCAN exit:** when `idx`==N and the output register is free, clear `out_valid`, load `emit_count` from the running count, and go to DONE.
- **DONE:** `drain_done`=1 for this cycle, then return to IDLE.
- **`round_done` while `busy`:** ignored (no re-snapshot); `overrun` is set to 1. `overrun` clears only on `rst`.
- **Ordering:** entries always leave in ascending node order; node index is not sorted by address.
- **Count width:** `emit_count` covers 0..N without wrap.
- **`rst` asserted at any time:**
  - State returns to IDLE.
  - `out_valid`, `busy`, `drain_done`, `overrun`, `emit_count`, `out_node`, `out_addr`, `out_data` and the snapshot all go to 0.
  - An in-flight drain is abandoned with no `drain_done`.

## Timing
- Edge E0 samples `round_done`; from E0 onward `busy`=1.
- With `out_ready`=1 throughout:
  - Edge Ek (k=1..N) examines node k-1.
  - A valid entry appears on the outputs after Ek and is accepted at Ek+1.
- Edge EN+1 enters DONE, so `drain_done` is high in the cycle after EN+1. Edge EN+2 returns to IDLE.
- Drain latency is N+2 cycles regardless of how many entries are valid.
- Every cycle of `out_valid && !out_ready` adds exactly one cycle to the drain.
- A `round_done` in the cycle immediately after the DONE cycle (state IDLE) is accepted normally.

## Test plan
- **All valid:** `mesh_db` N=4, all nodes write data 2'b11, `round_done` pulse, `out_ready`=1 → four beats: node 0..3, data 11, consecutive cycles. `drain_done` occurs N+2 cycles after the pulse, with `emit_count`=4.
- **Sparse:** only nodes 1 and 3 valid, addr/data 10/01 and 00/11 → exactly two beats in order node1, node3. `emit_count`=2, `drain_done` at the same cycle offset as the all-valid case.
- **None valid:** all valid bits 0 → `out_valid` never rises, `drain_done` after N+2 cycles, `emit_count`=0.
- **Backpressure:** all valid, `out_ready` low for 3 cycles while node 1 is presented → the node 1 fields hold stable, no beat is lost or duplicated, and `drain_done` is delayed by exactly 3 cycles.
- **Overrun:** second `round_done` two cycles after the first → the first drain completes unchanged from its original snapshot, and `overrun`=1 stays set after `drain_done`.
- **Reset mid-drain:** assert `rst` after the second beat → all outputs read 0 immediately, with no `drain_done`. A new `round_done` after release starts a clean drain, and its `emit_count` reflects only the new drain.

Source files
------------

// File: rtl/nanci_result_collector.sv
// Drains a snapshot of per-node nanci_result words onto a valid/ready stream,
// emitting valid entries in ascending node order and reporting count and overruns.
//
// state | meaning
// IDLE  | waiting for round_done
// SCAN  | walking the snapshot, emitting valid entries
// DONE  | single cycle, drain_done pulses
module nanci_result_collector #(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 2,
  parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     round_done,
  input  logic [N*(WIDTH+1)-1:0]   nanci_result_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_WIDTH-1:0]     out_node,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     drain_done,
  output logic [IDX_WIDTH:0]       emit_count,
  output logic                     overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH:0] N_IDX = (IDX_WIDTH+1)'(N);
  localparam logic [IDX_WIDTH:0] ONE   = (IDX_WIDTH+1)'(1);

  state_t                 state;
  logic [WIDTH:0]         snapshot [N];
  logic [IDX_WIDTH:0]     idx;
  logic [IDX_WIDTH:0]     count;
  logic [IDX_WIDTH-1:0]   idx_lo;
  logic [WIDTH:0]         cur;
  logic                   out_free;

  assign idx_lo   = idx[IDX_WIDTH-1:0];
  assign cur      = snapshot[idx_lo];
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_node   <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      drain_done <= 1'b0;
      emit_count <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < N; i++) snapshot[i] <= '0;
    end else begin
      drain_done <= 1'b0;
      if (round_done && state != S_IDLE) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (round_done) begin
            for (int i = 0; i < N; i++)
              snapshot[i] <= nanci_result_flat[i*(WIDTH+1) +: (WIDTH+1)];
            idx   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // a stalled beat freezes the whole scan so its fields stay stable
          if (out_free) begin
            if (idx < N_IDX) begin
              if (cur[WIDTH]) begin
                out_valid <= 1'b1;
                out_node  <= idx_lo;
                out_addr  <= cur[WIDTH-1:DATA_WIDTH];
                out_data  <= cur[DATA_WIDTH-1:0];
                count     <= count + ONE;
              end else begin
                out_valid <= 1'b0;
              end
              idx <= idx + ONE;
            end else begin
              out_valid  <= 1'b0;
              emit_count <= count;
              drain_done <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nanci_result_collector.sv
// Directed table-driven bench for nanci_result_collector: drains, backpressure,
// overrun and mid-drain reset.
module tb_nanci_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        round_done;
  logic [19:0] nanci_result_flat;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_node;
  logic [1:0]  out_addr;
  logic [1:0]  out_data;
  logic        busy;
  logic        drain_done;
  logic [2:0]  emit_count;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit ovr_exp = 1'b0;

  always #5 clk = ~clk;

  nanci_result_collector dut (
    .clk(clk), .rst(rst), .round_done(round_done),
    .nanci_result_flat(nanci_result_flat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_node(out_node), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .drain_done(drain_done), .emit_count(emit_count),
    .overrun(overrun)
  );

  typedef struct {
    logic [19:0]      flat;
    logic [19:0]      flat2;
    bit               ovr;
    int               stall_start;
    int               stall_len;
    int               exp_emit;
    int               exp_lat;
    logic [3:0][5:0]  beats;   // {node, addr, data} per expected beat
  } vec_t;

  vec_t rows [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at a negedge; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_drain(input vec_t v);
    int        cyc;
    int        nb;
    bit        done;
    bit        prev_stall;
    logic [5:0] prev_fields;
    nanci_result_flat = v.flat;
    round_done = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    round_done = 1'b0;
    check("busy_after_e0", {31'b0, busy}, 32'd1);
    cyc = 0; nb = 0; done = 1'b0; prev_stall = 1'b0; prev_fields = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      out_ready = !(cyc >= v.stall_start && cyc < v.stall_start + v.stall_len);
      if (v.ovr && cyc == 1) begin
        nanci_result_flat = v.flat2;
        round_done = 1'b1;
        ovr_exp = 1'b1;
      end else begin
        round_done = 1'b0;
      end
      if (prev_stall)
        check("stall_fields_stable", {26'b0, out_valid, out_node, out_addr, out_data},
              {26'b0, 1'b1, prev_fields});
      if (out_valid && out_ready) begin
        if (nb < 4) check("beat", {26'b0, out_node, out_addr, out_data}, {26'b0, v.beats[nb]});
        nb++;
      end
      prev_stall  = out_valid && !out_ready;
      prev_fields = {out_node, out_addr, out_data};
      if (drain_done) begin
        done = 1'b1;
        check("latency", cyc, v.exp_lat);
        check("valid_low_at_done", {31'b0, out_valid}, 32'd0);
        check("emit_count", {29'b0, emit_count}, v.exp_emit);
      end
      cyc++;
    end
    round_done = 1'b0;
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    check("beat_total", nb, v.exp_emit);
    @(negedge clk);
    check("idle_after_done", {30'b0, busy, drain_done}, 32'd0);
    check("overrun_flag", {31'b0, overrun}, {31'b0, ovr_exp});
  endtask

  initial begin
    // {flat, flat2, ovr, stall_start, stall_len, exp_emit, exp_lat, beats}
    rows[0] = '{20'b11111_11011_10111_10011, 20'b0, 1'b0, 0, 0, 4, 5,
                {6'b111111, 6'b101011, 6'b010111, 6'b000011}};
    rows[1] = '{20'b10011_01010_11001_01111, 20'b0, 1'b0, 0, 0, 2, 5,
                {6'b0, 6'b0, 6'b110011, 6'b011001}};
    rows[2] = '{20'b01111_00101_01010_00000, 20'b0, 1'b0, 0, 0, 0, 5,
                {6'b0, 6'b0, 6'b0, 6'b0}};
    rows[3] = '{20'b00111_11100_01001_10110, 20'b0, 1'b0, 0, 0, 2, 5,
                {6'b0, 6'b0, 6'b101100, 6'b000110}};
    rows[4] = '{20'b11111_11011_10111_10011, 20'b0, 1'b0, 2, 3, 4, 8,
                {6'b111111, 6'b101011, 6'b010111, 6'b000011}};
    rows[5] = '{20'b11111_11011_10111_10011, 20'b10011_01010_11001_01111, 1'b1, 0, 0, 4, 5,
                {6'b111111, 6'b101011, 6'b010111, 6'b000011}};

    rst = 1'b1;
    round_done = 1'b0;
    out_ready = 1'b1;
    nanci_result_flat = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {22'b0, out_valid, out_node, out_addr, out_data, busy, drain_done, overrun},
          32'd0);
    check("reset_emit_count", {29'b0, emit_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) run_drain(rows[r]);

    // reset mid-drain, just after the second beat is accepted
    nanci_result_flat = rows[0].flat;
    round_done = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    round_done = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_node", {30'b0, out_node}, 32'd2);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {22'b0, out_valid, out_node, out_addr, out_data, busy, drain_done, overrun},
          32'd0);
    check("midreset_emit_count", {29'b0, emit_count}, 32'd4 & 32'd0);
    ovr_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_reset", {30'b0, drain_done, busy}, 32'd0);
    end
    run_drain(rows[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
